// File: rtl/mips_pkg.sv
// Shared MIPS instruction-word definitions: field bit positions, fetch FSM states
// and instruction-register constants used by the fetch register and decode.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 25;
  localparam int TGT_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    HOLD = 2'b10
  } ir_state_e;

endpackage

// File: rtl/instr_field_split.sv
// Combinational splitter of a 32-bit MIPS word into its R/I/J-format fields.
module instr_field_split
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output logic [5:0]         o_opcode,
  output logic [4:0]         o_rs,
  output logic [4:0]         o_rt,
  output logic [4:0]         o_rd,
  output logic [4:0]         o_shamt,
  output logic [5:0]         o_funct,
  output logic [15:0]        o_imm16,
  output logic [25:0]        o_target26
);

  assign o_opcode   = i_instr[OPC_HI:OPC_LO];
  assign o_rs       = i_instr[RS_HI:RS_LO];
  assign o_rt       = i_instr[RT_HI:RT_LO];
  assign o_rd       = i_instr[RD_HI:RD_LO];
  assign o_shamt    = i_instr[SH_HI:SH_LO];
  assign o_funct    = i_instr[FN_HI:FN_LO];
  assign o_imm16    = i_instr[IMM_HI:IMM_LO];
  assign o_target26 = i_instr[TGT_HI:TGT_LO];

endmodule

// File: rtl/instr_fetch_reg.sv
// Multicycle instruction register: memory read handshake, word latch and field split.
// Optional bus timeout enabled by defining IR_TIMEOUT_EN.
module instr_fetch_reg
  import mips_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_fetch_start,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_busy,
  output logic              o_ir_valid,
  output logic              o_addr_err,
  output logic              o_bus_err,
  output logic [31:0]       o_instr,
  output logic [5:0]        o_opcode,
  output logic [4:0]        o_rs,
  output logic [4:0]        o_rt,
  output logic [4:0]        o_rd,
  output logic [4:0]        o_shamt,
  output logic [5:0]        o_funct,
  output logic [15:0]       o_imm16,
  output logic [25:0]       o_target26
);

  ir_state_e            r_state,    w_state_nxt;
  logic                 r_mem_req,  w_mem_req_nxt;
  logic [ADDR_W-1:0]    r_mem_addr, w_mem_addr_nxt;
  logic                 r_busy,     w_busy_nxt;
  logic                 r_ir_valid, w_ir_valid_nxt;
  logic                 r_addr_err, w_addr_err_nxt;
  logic                 r_bus_err,  w_bus_err_nxt;
  logic [INSTR_W-1:0]   r_instr,    w_instr_nxt;

`ifdef IR_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
`endif

  // Next-state and next-output decision; flush overrides everything else.
  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_busy_nxt     = r_busy;
    w_ir_valid_nxt = r_ir_valid;
    w_addr_err_nxt = 1'b0;
    w_bus_err_nxt  = 1'b0;
    w_instr_nxt    = r_instr;
`ifdef IR_TIMEOUT_EN
    w_cnt_nxt      = r_cnt;
`endif
    if (i_flush) begin
      w_state_nxt    = IDLE;
      w_mem_req_nxt  = 1'b0;
      w_busy_nxt     = 1'b0;
      w_ir_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if (i_fetch_start) begin
            w_ir_valid_nxt = 1'b0;
            if (i_pc[1:0] == 2'b00) begin
              w_state_nxt    = WAIT;
              w_mem_req_nxt  = 1'b1;
              w_mem_addr_nxt = i_pc;
              w_busy_nxt     = 1'b1;
`ifdef IR_TIMEOUT_EN
              w_cnt_nxt      = '0;
`endif
            end else begin
              w_state_nxt    = IDLE;
              w_addr_err_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        WAIT: begin
          // Request and address stay frozen here; fetch_start is deliberately ignored.
          if (i_mem_ack) begin
            w_state_nxt    = HOLD;
            w_instr_nxt    = i_mem_rdata;
            w_mem_req_nxt  = 1'b0;
            w_busy_nxt     = 1'b0;
            w_ir_valid_nxt = 1'b1;
`ifdef IR_TIMEOUT_EN
          end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            w_state_nxt    = IDLE;
            w_mem_req_nxt  = 1'b0;
            w_busy_nxt     = 1'b0;
            w_ir_valid_nxt = 1'b0;
            w_bus_err_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
`else
          end else begin
            w_state_nxt = WAIT;
          end
`endif
        end
        default: begin
          w_state_nxt    = IDLE;
          w_mem_req_nxt  = 1'b0;
          w_busy_nxt     = 1'b0;
          w_ir_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_ir_valid <= 1'b0;
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
      r_instr    <= NOP_WORD;
`ifdef IR_TIMEOUT_EN
      r_cnt      <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_busy     <= w_busy_nxt;
      r_ir_valid <= w_ir_valid_nxt;
      r_addr_err <= w_addr_err_nxt;
      r_bus_err  <= w_bus_err_nxt;
      r_instr    <= w_instr_nxt;
`ifdef IR_TIMEOUT_EN
      r_cnt      <= w_cnt_nxt;
`endif
    end
  end

  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_busy     = r_busy;
  assign o_ir_valid = r_ir_valid;
  assign o_addr_err = r_addr_err;
  assign o_bus_err  = r_bus_err;
  assign o_instr    = r_instr;

  instr_field_split u_split (
    .i_instr    (r_instr),
    .o_opcode   (o_opcode),
    .o_rs       (o_rs),
    .o_rt       (o_rt),
    .o_rd       (o_rd),
    .o_shamt    (o_shamt),
    .o_funct    (o_funct),
    .o_imm16    (o_imm16),
    .o_target26 (o_target26)
  );

endmodule

// File: doc/instr_fetch_reg.md
Name: instr_fetch_reg

Overview:
- Multicycle-datapath instruction register with memory-read handshake.
- On a fetch command from the control FSM, issues a word read at PC, waits for memory acknowledge, and latches the returned word.
- Holds the word stable and splits it into MIPS fields.
- imm16 feeds the sign-extension stage directly downstream; opcode/funct feed control decode.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction word width; fixed at 32 for MIPS field split.
- TIMEOUT_CYC, 16, cycles to wait for mem_ack before bus error. Used only with IR_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_start  in  1  control FSM request to fetch the instruction at pc.
- flush  in  1  abort any fetch in progress and invalidate the IR.
- pc  in  ADDR_W  fetch address.
- mem_req  out  1  read request to memory.
- mem_addr  out  ADDR_W  read address; stable while mem_req is high.
- mem_rdata  in  DATA_W  read data; valid when mem_ack is high.
- mem_ack  in  1  read-complete strobe.
- busy  out  1  fetch outstanding.
- ir_valid  out  1  instr holds a fetched word.
- addr_err  out  1  one-cycle pulse: misaligned pc.
- bus_err  out  1  one-cycle pulse: timeout. Tied 0 when IR_TIMEOUT_EN is not defined.
- instr  out  32  latched instruction word.
- opcode  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  instr[15:11].
- shamt  out  5  instr[10:6].
- funct  out  6  instr[5:0].
- imm16  out  16  instr[15:0], to sign extension.
- target26  out  26  instr[25:0].

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_req=0, mem_addr=0, busy=0, ir_valid=0, addr_err=0, bus_err=0, instr=0 (NOP). All fields follow instr.
- FSM states: IDLE, WAIT, HOLD.
- IDLE or HOLD, fetch_start=1, pc[1:0]==0: next edge enters WAIT with mem_addr=pc, mem_req=1, busy=1, ir_valid=0.
- IDLE or HOLD, fetch_start=1, pc[1:0]!=0: no request. addr_err pulses 1 cycle. ir_valid cleared. Next state is IDLE.
- WAIT: mem_req and mem_addr held constant until ack. fetch_start is ignored.
- WAIT, mem_ack=1 sampled at an edge: instr<=mem_rdata, mem_req<=0, busy<=0, ir_valid<=1, next state HOLD.
- Minimum latency: fetch_start at edge N, ack at edge N+1, ir_valid/instr updated after edge N+1 (2 cycles).
- instr changes only on an accepted ack; it keeps its old value throughout a new fetch. Multicycle stages rely on this.
- mem_ack outside WAIT is ignored.
- flush=1 in any state: next state IDLE, mem_req=0, busy=0, ir_valid=0; instr retained.
- flush has priority over mem_ack and fetch_start in the same cycle.
- Fields are pure wiring from instr; no extra latency.

Optional Feature:
- IR_TIMEOUT_EN defined:
  - Counter cleared on entering WAIT, incremented each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYC-1 without ack: mem_req drops, bus_err pulses 1 cycle, ir_valid=0, next state IDLE.
  - Ack on that same cycle wins: normal capture, no bus_err.
- IR_TIMEOUT_EN undefined: no counter; WAIT persists until ack or flush; bus_err constant 0.

Decomposition:
- Shared package mips_pkg:
  - field bit-position constants (OPC_HI/LO, RS_HI/LO, ..., IMM_HI/LO);
  - state enum typedef {IDLE, WAIT, HOLD};
  - INSTR_W=32, NOP_WORD=32'h0.
- One natural sub-module: instr_field_split, a combinational word-to-fields splitter, reused by decode.

Test Plan:
- Reset then fetch_start with pc=0x00400000, ack one cycle later with rdata=0x2008BEEF → mem_req high 1 cycle; opcode=0x08, rs=0, rt=8, imm16=0xBEEF; ir_valid=1 two cycles after fetch_start.
- pc=0x00400004, ack delayed 5 cycles → mem_req/mem_addr stable for 5 cycles; prior instr unchanged until ack; fetch_start pulses during WAIT ignored.
- pc=0x00400002 → addr_err single pulse, mem_req never asserts, state IDLE.
- flush and mem_ack asserted in the same WAIT cycle → ir_valid=0, instr keeps old value, state IDLE.
- IR_TIMEOUT_EN, TIMEOUT_CYC=16, no ack → bus_err pulse exactly 16 cycles after mem_req rises, then mem_req=0; without the macro, mem_req is still high after 100 cycles.
- rst_n dropped mid-WAIT → mem_req, busy, ir_valid go to 0 immediately (asynchronously) and instr=0.
